// File: rtl/alu_adder_arbiter.sv
// alu_adder_arbiter: shares one external 32-bit carry-select adder between two
// requesters. Round-robin arbitration, 64-bit ops run as two chained passes
// (low word then high word), and the result plus N/Z/C/V is held on a
// registered response port until the consumer takes it.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. Requesters hold valid and operands until ready; ready is combinational
// and only asserted inside the accept window (IDLE, or RSP while rsp_ready=1).
// The response side holds rsp_valid and every rsp_* field until rsp_ready.
module alu_adder_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_sub,
    input  logic        req0_wide,
    input  logic [63:0] req0_a,
    input  logic [63:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_sub,
    input  logic        req1_wide,
    input  logic [63:0] req1_a,
    input  logic [63:0] req1_b,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_cin,
    input  logic [31:0] add_sum,
    input  logic        add_cout,
    input  logic        add_cprev,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [63:0] rsp_result,
    output logic        rsp_n,
    output logic        rsp_z,
    output logic        rsp_c,
    output logic        rsp_v
);

    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_RSP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_last_grant;
    logic [63:0] r_a;
    logic [63:0] r_b;
    logic        r_sub;
    logic        r_wide;
    logic        r_id;
    logic [63:0] r_result;
    logic        r_carry;
    logic        r_n;
    logic        r_z;
    logic        r_c;
    logic        r_v;

    logic        w_window;
    logic        w_accept;
    logic        w_grant;
    logic        w_sum_zero;

    // Ready is held low while reset is asserted even though the state reads IDLE.
    assign w_window = rst_n && ((r_state == S_IDLE) || ((r_state == S_RSP) && rsp_ready));
    assign w_accept = w_window && (req0_valid || req1_valid);
    // With both pending, the requester that did not win last time goes next.
    assign w_grant  = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;

    assign req0_ready = w_accept && !w_grant;
    assign req1_ready = w_accept &&  w_grant;

    assign w_sum_zero = (add_sum == 32'd0);

    assign rsp_valid  = (r_state == S_RSP);
    assign rsp_id     = r_id;
    assign rsp_result = r_result;
    assign rsp_n      = r_n;
    assign rsp_z      = r_z;
    assign rsp_c      = r_c;
    assign rsp_v      = r_v;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state: accept starts LO, wide ops take an extra HI pass.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_LO;
            S_LO:    w_next = r_wide ? S_HI : S_RSP;
            S_HI:    w_next = S_RSP;
            S_RSP:   if (rsp_ready) w_next = w_accept ? S_LO : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Adder operand steering; subtraction is A + ~B + 1 with the +1 on carry-in.
    always_comb begin
        add_a   = 32'd0;
        add_b   = 32'd0;
        add_cin = 1'b0;
        case (r_state)
            S_LO: begin
                add_a   = r_a[31:0];
                add_b   = r_sub ? ~r_b[31:0] : r_b[31:0];
                add_cin = r_sub;
            end
            S_HI: begin
                add_a   = r_a[63:32];
                add_b   = r_sub ? ~r_b[63:32] : r_b[63:32];
                add_cin = r_carry;
            end
            default: begin
                add_a   = 32'd0;
                add_b   = 32'd0;
                add_cin = 1'b0;
            end
        endcase
    end

    // Latch the granted request's operands and remember who won.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a          <= 64'd0;
            r_b          <= 64'd0;
            r_sub        <= 1'b0;
            r_wide       <= 1'b0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_a          <= w_grant ? req1_a    : req0_a;
            r_b          <= w_grant ? req1_b    : req0_b;
            r_sub        <= w_grant ? req1_sub  : req0_sub;
            r_wide       <= w_grant ? req1_wide : req0_wide;
            r_id         <= w_grant;
            r_last_grant <= w_grant;
        end
    end

    // Capture adder passes; flags come from whichever pass is the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= 64'd0;
            r_carry  <= 1'b0;
            r_n      <= 1'b0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
        end else if (r_state == S_LO) begin
            r_result <= {32'd0, add_sum};
            r_carry  <= add_cout;
            if (!r_wide) begin
                r_n <= add_sum[31];
                r_z <= w_sum_zero;
                r_c <= add_cout;
                r_v <= add_cout ^ add_cprev;
            end
        end else if (r_state == S_HI) begin
            r_result[63:32] <= add_sum;
            r_n <= add_sum[31];
            r_z <= w_sum_zero && (r_result[31:0] == 32'd0);
            r_c <= add_cout;
            r_v <= add_cout ^ add_cprev;
        end
    end

endmodule

// File: tb/tb_alu_adder_arbiter.sv
// Bench for alu_adder_arbiter: models the shared adder, issues directed
// requests, and scores every response against an expected-result queue.
module tb_alu_adder_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_sub, req0_wide;
    logic [63:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_sub, req1_wide;
    logic [63:0] req1_a, req1_b;
    logic [31:0] add_a, add_b, add_sum;
    logic        add_cin, add_cout, add_cprev;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [63:0] rsp_result;
    logic        rsp_n, rsp_z, rsp_c, rsp_v;

    typedef struct packed {
        logic        id;
        logic [63:0] res;
        logic [3:0]  f;   // {n, z, c, v}
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Combinational adder seen by the DUT.
    logic [32:0] w_full;
    logic [31:0] w_low;
    assign w_full    = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
    assign w_low     = {1'b0, add_a[30:0]} + {1'b0, add_b[30:0]} + {31'd0, add_cin};
    assign add_sum   = w_full[31:0];
    assign add_cout  = w_full[32];
    assign add_cprev = w_low[31];

    alu_adder_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sub(req0_sub),
        .req0_wide(req0_wide), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sub(req1_sub),
        .req1_wide(req1_wide), .req1_a(req1_a), .req1_b(req1_b),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout), .add_cprev(add_cprev),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_n(rsp_n), .rsp_z(rsp_z),
        .rsp_c(rsp_c), .rsp_v(rsp_v)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic: two's complement add/sub with signed-overflow rule.
    function automatic rsp_t model(input logic id, input logic sub, input logic wide,
                                   input logic [63:0] a, input logic [63:0] b);
        rsp_t        r;
        logic [63:0] bb;
        logic [64:0] s;
        logic [32:0] s32;
        bb   = sub ? ~b : b;
        r.id = id;
        if (wide) begin
            s     = {1'b0, a} + {1'b0, bb} + {64'd0, sub};
            r.res = s[63:0];
            r.f   = {s[63], (s[63:0] == 64'd0), s[64], (a[63] == bb[63]) && (s[63] != a[63])};
        end else begin
            s32   = {1'b0, a[31:0]} + {1'b0, bb[31:0]} + {32'd0, sub};
            r.res = {32'd0, s32[31:0]};
            r.f   = {s32[31], (s32[31:0] == 32'd0), s32[32], (a[31] == bb[31]) && (s32[31] != a[31])};
        end
        return r;
    endfunction

    task automatic drive_req(input logic id, input logic v, input logic sub, input logic wide,
                             input logic [63:0] a, input logic [63:0] b);
        if (id) begin
            req1_valid = v; req1_sub = sub; req1_wide = wide; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_sub = sub; req0_wide = wide; req0_a = a; req0_b = b;
        end
    endtask

    // Raise a request, wait (bounded) for its ready, score it, then drop valid.
    // Returns #1 after the accept edge, i.e. inside the LO cycle.
    task automatic send(input logic id, input logic sub, input logic wide,
                        input logic [63:0] a, input logic [63:0] b);
        int n;
        logic rdy;
        drive_req(id, 1'b1, sub, wide, a, b);
        n = 0;
        @(negedge clk);
        rdy = id ? req1_ready : req0_ready;
        while (!rdy && n < 20) begin
            @(negedge clk);
            rdy = id ? req1_ready : req0_ready;
            n++;
        end
        check("accept", 64'(rdy), 64'd1);
        exp_q.push_back(model(id, sub, wide, a, b));
        @(posedge clk); #1;
        drive_req(id, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Response scoreboard and single-grant monitor.
    always @(negedge clk) begin
        if (rst_n && (req0_ready || req1_ready))
            check("one_ready", 64'(req0_ready & req1_ready), 64'd0);
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_id", 64'(rsp_id), 64'(mon_e.id));
                check("rsp_result", rsp_result, mon_e.res);
                check("rsp_nzcv", 64'({rsp_n, rsp_z, rsp_c, rsp_v}), 64'(mon_e.f));
            end
        end
    end

    initial begin
        logic [63:0] cur_a[2];
        logic [63:0] cur_b[2];
        rsp_t        hold;
        logic        exp_id;
        int          n;

        // Reset, with a request pending to confirm ready stays low.
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        drive_req(1'b0, 1'b1, 1'b0, 1'b0, 64'd3, 64'd4);
        drive_req(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_result", rsp_result, 64'd0);
        check("rst_flags", 64'({rsp_id, rsp_n, rsp_z, rsp_c, rsp_v}), 64'd0);
        check("rst_req0_ready", 64'(req0_ready), 64'd0);
        check("rst_add", {add_a, add_b} | 64'(add_cin), 64'd0);
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Narrow add with overflow; response one cycle after LO.
        send(1'b0, 1'b0, 1'b0, 64'h0000_0000_7FFF_FFFF, 64'd1);
        @(negedge clk);
        check("lo_add_a", 64'(add_a), 64'h7FFF_FFFF);
        check("lo_add_b", 64'(add_b), 64'd1);
        check("lo_rsp_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check("narrow_rsp_valid", 64'(rsp_valid), 64'd1);
        @(posedge clk); #1;
        drain();

        // Narrow sub from req1: inverted B and carry-in 1 during LO.
        send(1'b1, 1'b1, 1'b0, 64'd5, 64'd5);
        @(negedge clk);
        check("sub_add_cin", 64'(add_cin), 64'd1);
        check("sub_add_b", 64'(add_b), 64'hFFFF_FFFA);
        drain();

        // Wide add: carry out of the low pass feeds the high pass.
        send(1'b0, 1'b0, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1);
        @(negedge clk);
        check("wide_lo_rsp_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check("wide_hi_add_cin", 64'(add_cin), 64'd1);
        check("wide_hi_rsp_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check("wide_rsp_valid", 64'(rsp_valid), 64'd1);
        drain();

        // Wide sub producing all ones.
        send(1'b1, 1'b1, 1'b1, 64'd0, 64'd1);
        drain();

        // Contention after reset: grants must alternate 0,1,0,1.
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cur_a[i] = {$urandom, $urandom};
            cur_b[i] = {$urandom, $urandom};
            drive_req(1'(i), 1'b1, 1'(i), 1'b0, cur_a[i], cur_b[i]);
        end
        for (int g = 0; g < 4; g++) begin
            exp_id = 1'(g % 2);
            n = 0;
            @(negedge clk);
            while (!(req0_ready || req1_ready) && n < 10) begin
                @(negedge clk);
                n++;
            end
            check("grant_order", 64'(req1_ready), 64'(exp_id));
            exp_q.push_back(model(exp_id, exp_id, 1'b0, cur_a[exp_id], cur_b[exp_id]));
            @(posedge clk); #1;
            cur_a[exp_id] = {$urandom, $urandom};
            cur_b[exp_id] = {$urandom, $urandom};
            drive_req(exp_id, 1'b1, exp_id, 1'b0, cur_a[exp_id], cur_b[exp_id]);
        end
        drive_req(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        drive_req(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        drain();

        // Backpressure: response held, new request waits, then accepted on release.
        rsp_ready = 1'b0;
        cur_a[0] = 64'(32'($urandom_range(0, 1000)));
        cur_b[0] = 64'(32'($urandom_range(0, 1000)));
        hold = model(1'b0, 1'b1, 1'b0, cur_a[0], cur_b[0]);
        send(1'b0, 1'b1, 1'b0, cur_a[0], cur_b[0]);
        @(posedge clk); #1;
        cur_a[1] = 64'h0000_0000_1234_5678;
        cur_b[1] = 64'h0000_0000_0000_1111;
        drive_req(1'b0, 1'b1, 1'b0, 1'b0, cur_a[1], cur_b[1]);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            check("bp_rsp_result", rsp_result, hold.res);
            check("bp_rsp_flags", 64'({rsp_id, rsp_n, rsp_z, rsp_c, rsp_v}), 64'({hold.id, hold.f}));
            check("bp_req0_ready", 64'(req0_ready), 64'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 64'(req0_ready), 64'd1);
        exp_q.push_back(model(1'b0, 1'b0, 1'b0, cur_a[1], cur_b[1]));
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        @(negedge clk);
        check("bp_lo_add_a", 64'(add_a), 64'h1234_5678);
        check("bp_lo_rsp_valid", 64'(rsp_valid), 64'd0);
        drain();

        // Reset during HI of a wide op aborts it and restores req0 priority.
        send(1'b0, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0001, 64'h0000_0001_FFFF_FFFF);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        check("abort_add", {add_a, add_b} | 64'(add_cin), 64'd0);
        check("abort_rsp_result", rsp_result, 64'd0);
        check("abort_flags", 64'({rsp_id, rsp_n, rsp_z, rsp_c, rsp_v}), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_req(1'b0, 1'b1, 1'b0, 1'b0, 64'd100, 64'd23);
        drive_req(1'b1, 1'b1, 1'b1, 1'b0, 64'd7, 64'd9);
        @(negedge clk);
        check("post_rst_req0_ready", 64'(req0_ready), 64'd1);
        check("post_rst_req1_ready", 64'(req1_ready), 64'd0);
        exp_q.push_back(model(1'b0, 1'b0, 1'b0, 64'd100, 64'd23));
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        send(1'b1, 1'b1, 1'b0, 64'd7, 64'd9);
        drain();

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
